// File: rtl/led_stretch.sv
// Per-channel event stretcher driving PWM-dimmed, active-low LED pins.
// Active rises on the event edge; pins follow active one cycle later.
module led_stretch #(
  parameter int DELAY = 24,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] events,
  input  logic [3:0]       brightness,
  input  logic             lamp_test,
  output logic [WIDTH-1:0] active,
  output logic [WIDTH-1:0] led_pins
);

  localparam logic [DELAY-1:0] HOLD_MAX = '1;
  localparam logic [3:0]       PWM_LAST = 4'd14;

  logic [DELAY-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pins;
  logic [3:0]       r_pwm;
  logic [3:0]       r_bright;

  logic             w_wrap;
  logic             w_pwm_on;
  logic [3:0]       w_pwm_next;

  // Duty only changes at the period boundary so no PWM period is cut short.
  assign w_wrap     = (r_pwm == PWM_LAST);
  assign w_pwm_next = w_wrap ? 4'd0 : r_pwm + 4'd1;
  assign w_pwm_on   = (r_pwm < r_bright);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pwm    <= 4'd0;
      r_bright <= 4'hF;
    end else begin
      r_pwm <= w_pwm_next;
      if (w_wrap) begin
        r_bright <= brightness;
      end
    end
  end

  // Counter reaches 0 one edge before active drops, giving 2^DELAY cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (events[i]) begin
          r_cnt[i]    <= HOLD_MAX;
          r_active[i] <= 1'b1;
        end else if (r_active[i]) begin
          if (r_cnt[i] != '0) begin
            r_cnt[i] <= r_cnt[i] - DELAY'(1);
          end else begin
            r_active[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pins <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_pins[i] <= ~((r_active[i] & w_pwm_on) | lamp_test);
      end
    end
  end

  assign active   = r_active;
  assign led_pins = r_pins;

endmodule

// File: tb/tb_led_stretch.sv
// Directed bench for led_stretch with DELAY=4, WIDTH=8.
module tb_led_stretch;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] events;
  logic [3:0] brightness;
  logic       lamp_test;
  logic [7:0] active;
  logic [7:0] led_pins;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  led_stretch #(.DELAY(4), .WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .events     (events),
    .brightness (brightness),
    .lamp_test  (lamp_test),
    .active     (active),
    .led_pins   (led_pins)
  );

  typedef struct {
    logic [7:0] ev;
    logic       lt;
    logic       rst;
    logic [7:0] exp_act;
    logic [7:0] exp_pins;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [7:0] ev, logic lt, logic rst,
                              logic [7:0] ea, logic [7:0] ep);
    vec_t v;
    v.ev = ev; v.lt = lt; v.rst = rst; v.exp_act = ea; v.exp_pins = ep;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Held event on channel 3; duty in effect per edge j after reset given by the caller.
  task automatic pwm_run(input int n, input int chg_edge, input logic [3:0] br_a,
                         input logic [3:0] br_b, input int duty_edge_a, input int duty_edge_b,
                         input int duty_b, input int duty_c, input string tag);
    logic [7:0] exp_p;
    int duty;
    reset = 1'b1; events = 8'h00; brightness = br_a; lamp_test = 1'b0;
    tick();
    check({tag, "_rst_pins"}, led_pins, 8'hFF);
    reset = 1'b0; events = 8'h08;
    for (int j = 1; j <= n; j++) begin
      if (j == chg_edge) brightness = br_b;
      tick();
      if (j <= duty_edge_a)      duty = 15;
      else if (j <= duty_edge_b) duty = duty_b;
      else                       duty = duty_c;
      if (j == 1) exp_p = 8'hFF;
      else        exp_p = (((j - 1) % 15) < duty) ? 8'hF7 : 8'hFF;
      check($sformatf("%s_act_%0d", tag, j), active, 8'h08);
      check($sformatf("%s_pins_%0d", tag, j), led_pins, exp_p);
    end
    events = 8'h00;
  endtask

  initial begin
    reset = 1'b1; events = 8'h00; brightness = 4'd15; lamp_test = 1'b0;

    // Reset, single pulse
    add(8'h00, 0, 1, 8'h00, 8'hFF);
    add(8'h01, 0, 0, 8'h01, 8'hFF);
    for (int i = 1; i <= 15; i++) add(8'h00, 0, 0, 8'h01, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFF);
    // Retrigger at k+10: falls at k+26
    add(8'h01, 0, 0, 8'h01, 8'hFF);
    for (int i = 1; i <= 9; i++) add(8'h00, 0, 0, 8'h01, 8'hFE);
    add(8'h01, 0, 0, 8'h01, 8'hFE);
    for (int i = 11; i <= 25; i++) add(8'h00, 0, 0, 8'h01, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFF);
    // All channels at once, then reset mid-hold and restart
    add(8'hFF, 0, 0, 8'hFF, 8'hFF);
    for (int i = 1; i <= 4; i++) add(8'h00, 0, 0, 8'hFF, 8'h00);
    add(8'h00, 1, 1, 8'h00, 8'hFF);
    add(8'h01, 0, 0, 8'h01, 8'hFF);
    for (int i = 1; i <= 15; i++) add(8'h00, 0, 0, 8'h01, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFE);
    add(8'h00, 0, 0, 8'h00, 8'hFF);
    // Lamp test with no holds
    add(8'h00, 1, 0, 8'h00, 8'h00);
    add(8'h00, 1, 0, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 8'hFF);

    foreach (vecs[i]) begin
      events = vecs[i].ev; lamp_test = vecs[i].lt; reset = vecs[i].rst;
      tick();
      check($sformatf("vec%0d_active", i), active, vecs[i].exp_act);
      check($sformatf("vec%0d_pins", i), led_pins, vecs[i].exp_pins);
    end

    // Brightness 5 captured at edge 15, then 0 set before edge 46 and captured at edge 60
    pwm_run(75, 46, 4'd5, 4'd0, 15, 60, 5, 0, "pwm");
    // Brightness 15 -> 3 while pwm_count is 6; new duty starts at next period
    pwm_run(45, 22, 4'd15, 4'd3, 30, 1000, 3, 3, "bchg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_stretch.md
LED_STRETCH -- requirements
Module: led_stretch

Interface
REQ-001 SHALL have parameter DELAY, default 24, meaning log2 of the hold length in clock cycles (legal range 2..30).
REQ-002 SHALL have parameter WIDTH, default 8, meaning the number of event/LED channels.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port events  input  WIDTH  meaning per-channel event strobes, synchronous to clock, any pulse length.
REQ-006 SHALL have port brightness  input  4  meaning the PWM duty level (0 = off, 15 = full on).
REQ-007 SHALL have port lamp_test  input  1  meaning force all LEDs on at full brightness while high.
REQ-008 SHALL have port active  output  WIDTH  meaning a registered per-channel hold-in-progress flag.
REQ-009 SHALL have port led_pins  output  WIDTH  meaning registered active-low LED pin drive (0 = lit).

Function
REQ-010 SHALL keep a per-channel hold counter of DELAY bits and a per-channel active flag.
REQ-011 SHALL, when events[i] is high at edge k, load counter[i] with 2^DELAY-1 and set active[i] at edge k, whatever the channel state (retrigger).
REQ-012 SHALL, when active[i] is high, events[i] is low and counter[i] != 0, decrement counter[i] by 1.
REQ-013 SHALL, when active[i] is high, events[i] is low and counter[i] == 0, clear active[i]; a single-cycle event therefore holds active[i] high for exactly 2^DELAY cycles.
REQ-014 SHALL, while events[i] stays high, hold counter[i] at 2^DELAY-1, so that active[i] falls exactly 2^DELAY cycles after the last high cycle.
REQ-015 SHALL run the channels independently; simultaneous events on any set of channels are all honoured in the same cycle.
REQ-016 SHALL run a free-running 4-bit pwm_count that counts 0..14 and wraps from 14 to 0 (period 15 cycles).
REQ-017 SHALL capture brightness into bright_q only at the wrap cycle (pwm_count == 14), so that a duty change never truncates a PWM period.
REQ-018 SHALL define pwm_on = (pwm_count < bright_q); bright_q = 15 gives always on and 0 gives always off.
REQ-019 SHALL register led_pins[i] <= ~((active[i] & pwm_on) | lamp_test), so a pin follows active[i] with one cycle of latency.
REQ-020 SHALL let lamp_test override only led_pins; it SHALL NOT affect counters, active flags or the PWM.
REQ-021 SHALL not wrap the hold counter below 0; the counter holds at 0 while active[i] is low.

Reset
REQ-022 SHALL, when reset is high at a rising edge, clear all counters, active = 0, pwm_count = 0, bright_q = 15 and led_pins = all ones (all dark).
REQ-023 SHALL give reset priority over events and lamp_test in the same cycle; a hold in progress is aborted.
REQ-024 SHALL resume normal operation at the first edge with reset low; events in that cycle are honoured.

Verification (DELAY=4, WIDTH=8)
REQ-025 SHALL cover a single pulse: brightness=15, events=8'h01 for 1 cycle at edge k -> active[0] high for edges k..k+15, led_pins[0]=0 after edges k+1..k+16, and all other pins stay 1.
REQ-026 SHALL cover retrigger: a second pulse on channel 0 at edge k+10 -> active[0] stays high continuously until edge k+25 and falls at k+26.
REQ-027 SHALL cover PWM: brightness=5 and events[3] held high -> led_pins[3] is low 5 of every 15 cycles, aligned to pwm_count 0..4; brightness=0 -> led_pins[3] stays 1.
REQ-028 SHALL cover a brightness change mid-period: brightness changes 15->3 at pwm_count=6 -> the current period completes at full duty and the 3/15 duty starts at the next pwm_count=0.
REQ-029 SHALL cover simultaneous events and lamp_test: events=8'hFF -> all active bits set in the same edge; lamp_test=1 with no holds -> led_pins=8'h00 one cycle later, and back to 8'hFF one cycle after lamp_test falls.
REQ-030 SHALL cover reset mid-hold: reset for 1 cycle at edge k+5 of a hold -> active=0 and led_pins=8'hFF after edge k+5, and a new event at k+6 restarts a full 16-cycle hold.
